// File: rtl/sram_rd_arbiter.sv
// -----------------------------------------------------------------------------
// sram_rd_arbiter
//
// Purpose: arbitrates NUM_PORTS upstream read ports onto a single downstream
// SRAM read channel. Only one request is in flight at a time. The FSM walks
// IDLE -> REQ -> WAIT -> RESP -> IDLE. The refill data is returned on a shared
// s_data bus with a one-hot s_valid pulse to the requesting port.
//
// Handshakes:
//   upstream   : a port holds s_req; it is accepted in the cycle where its
//                s_rdy bit is high (IDLE only, one winner at most).
//   downstream : m_req/m_addr/m_type stay stable until the cycle m_req && m_rdy.
//                m_valid is then a single-cycle data pulse, honoured in WAIT only.
//   abort      : s_abort[granted] in REQ/WAIT only hides the s_valid pulse.
//                The downstream transaction still runs to completion.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   s_req/s_addr/s_type per-port request, address and type (sliced per port)
//   s_abort             per-port abort of the outstanding request
//   s_rdy               one-hot accept (IDLE only)
//   s_valid/s_data      one-hot response strobe and shared response data
//   m_req/m_addr/m_type downstream request
//   m_rdy               downstream accepts the request
//   m_valid/m_data      downstream data pulse
//   busy                FSM is not in IDLE
// -----------------------------------------------------------------------------
module sram_rd_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int TYPE_W    = 6,
  parameter int RR_MODE   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        s_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] s_addr,
  input  logic [NUM_PORTS*TYPE_W-1:0] s_type,
  input  logic [NUM_PORTS-1:0]        s_abort,
  output logic [NUM_PORTS-1:0]        s_rdy,
  output logic [NUM_PORTS-1:0]        s_valid,
  output logic [DATA_W-1:0]           s_data,
  output logic                        m_req,
  output logic [ADDR_W-1:0]           m_addr,
  output logic [TYPE_W-1:0]           m_type,
  input  logic                        m_rdy,
  input  logic                        m_valid,
  input  logic [DATA_W-1:0]           m_data,
  output logic                        busy
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    last_grant_q;
  logic [IDX_W-1:0]    grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [TYPE_W-1:0]   type_q;
  logic [DATA_W-1:0]   data_q;
  logic                aborted_q;

  logic [IDX_W-1:0]    winner;
  logic                found;
  logic                any_req;
  int                  cand;

  assign any_req = |s_req;

  // Winner search. Round-robin starts one past the last grant and wraps;
  // fixed priority simply scans upward from port 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (RR_MODE != 0) begin
        cand = (int'(last_grant_q) + 1 + k) % NUM_PORTS;
      end else begin
        cand = k;
      end
      if (!found && s_req[cand]) begin
        found  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
  end

  // Accept is only offered in IDLE. It is gated by rst_n so that s_rdy is
  // also low while reset is held.
  always_comb begin
    s_rdy = '0;
    if (rst_n && (state_q == ST_IDLE) && any_req) begin
      s_rdy[winner] = 1'b1;
    end
  end

  always_comb begin
    s_valid = '0;
    if ((state_q == ST_RESP) && !aborted_q) begin
      s_valid[grant_q] = 1'b1;
    end
  end

  assign m_req  = (state_q == ST_REQ);
  assign m_addr = addr_q;
  assign m_type = type_q;
  assign s_data = data_q;
  assign busy   = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      grant_q      <= '0;
      addr_q       <= '0;
      type_q       <= '0;
      data_q       <= '0;
      aborted_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            addr_q       <= s_addr[int'(winner)*ADDR_W +: ADDR_W];
            type_q       <= s_type[int'(winner)*TYPE_W +: TYPE_W];
            grant_q      <= winner;
            last_grant_q <= winner;
            state_q      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (s_abort[grant_q]) aborted_q <= 1'b1;
          if (m_rdy) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (s_abort[grant_q]) aborted_q <= 1'b1;
          if (m_valid) begin
            data_q  <= m_data;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Leaving RESP is the only way into IDLE, so the flag clears here.
          aborted_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_rd_arbiter
//
// Two instances share stimulus: one round-robin, one fixed priority. Only the
// selected instance sees s_req and s_abort. The other one stays idle, and its
// outputs are muxed away. The driver walks each transaction through the
// handshake. The expected response is queued at issue time, and a monitor pops
// it when s_valid appears.
// -----------------------------------------------------------------------------
module tb_sram_rd_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TW = 6;

  logic            clk;
  logic            rst_n;
  logic            use_fp;
  logic [N-1:0]    s_req;
  logic [N*AW-1:0] s_addr;
  logic [N*TW-1:0] s_type;
  logic [N-1:0]    s_abort;
  logic            m_rdy;
  logic            m_valid;
  logic [DW-1:0]   m_data;

  logic [N-1:0]  s_req_rr, s_req_fp, s_abort_rr, s_abort_fp;
  logic [N-1:0]  s_rdy_rr, s_rdy_fp, s_valid_rr, s_valid_fp;
  logic [DW-1:0] s_data_rr, s_data_fp;
  logic          m_req_rr, m_req_fp, busy_rr, busy_fp;
  logic [AW-1:0] m_addr_rr, m_addr_fp;
  logic [TW-1:0] m_type_rr, m_type_fp;

  logic [N-1:0]  s_rdy, s_valid;
  logic [DW-1:0] s_data;
  logic          m_req, busy;
  logic [AW-1:0] m_addr;
  logic [TW-1:0] m_type;

  assign s_req_rr   = use_fp ? '0 : s_req;
  assign s_req_fp   = use_fp ? s_req : '0;
  assign s_abort_rr = use_fp ? '0 : s_abort;
  assign s_abort_fp = use_fp ? s_abort : '0;

  assign s_rdy   = use_fp ? s_rdy_fp   : s_rdy_rr;
  assign s_valid = use_fp ? s_valid_fp : s_valid_rr;
  assign s_data  = use_fp ? s_data_fp  : s_data_rr;
  assign m_req   = use_fp ? m_req_fp   : m_req_rr;
  assign m_addr  = use_fp ? m_addr_fp  : m_addr_rr;
  assign m_type  = use_fp ? m_type_fp  : m_type_rr;
  assign busy    = use_fp ? busy_fp    : busy_rr;

  sram_rd_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .TYPE_W(TW), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .s_req(s_req_rr), .s_addr(s_addr), .s_type(s_type),
    .s_abort(s_abort_rr), .s_rdy(s_rdy_rr), .s_valid(s_valid_rr), .s_data(s_data_rr),
    .m_req(m_req_rr), .m_addr(m_addr_rr), .m_type(m_type_rr), .m_rdy(m_rdy),
    .m_valid(m_valid), .m_data(m_data), .busy(busy_rr)
  );

  sram_rd_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .TYPE_W(TW), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .s_req(s_req_fp), .s_addr(s_addr), .s_type(s_type),
    .s_abort(s_abort_fp), .s_rdy(s_rdy_fp), .s_valid(s_valid_fp), .s_data(s_data_fp),
    .m_req(m_req_fp), .m_addr(m_addr_fp), .m_type(m_type_fp), .m_rdy(m_rdy),
    .m_valid(m_valid), .m_data(m_data), .busy(busy_fp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW+7:0] exp_q[$];   // {port[7:0], data}
  int rr_last = N - 1;       // model: last round-robin grant

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int p);
    logic [N-1:0] r;
    r = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int w = 0; w < DW/32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference arbitration: round-robin takes the first requester after the
  // previous grant (cyclically); fixed priority takes the lowest requester.
  function automatic int model_pick(input logic [N-1:0] mask, input bit rr);
    if (rr) begin
      for (int k = 1; k <= N; k++) begin
        if (mask[(rr_last + k) % N]) return (rr_last + k) % N;
      end
    end else begin
      for (int p = 0; p < N; p++) begin
        if (mask[p]) return p;
      end
    end
    return 0;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (s_valid !== '0) begin
        if (exp_q.size() == 0) begin
          check("s_valid_unexpected", DW'(s_valid), '0);
        end else begin
          logic [DW+7:0] e;
          e = exp_q.pop_front();
          check("s_valid_port", DW'(s_valid), DW'(onehot(int'(e[DW +: 8]))));
          check("s_data", s_data, e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Starts and ends on a negedge with the selected DUT in IDLE.
  task automatic do_txn(input logic [N-1:0] mask, input int rdy_dly, input int val_dly,
                        input bit do_abort, input bit do_reset, input bit fixed);
    int win;
    logic [AW-1:0] a;
    logic [TW-1:0] t;
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) begin
      s_addr[i*AW +: AW] = $urandom;
      s_type[i*TW +: TW] = TW'($urandom);
    end
    d   = rand_data();
    win = model_pick(mask, !use_fp);
    if (fixed) begin
      s_addr[win*AW +: AW] = 32'h8000_1000;
      d = {(DW/8){8'hA5}};
    end
    a = s_addr[win*AW +: AW];
    t = s_type[win*TW +: TW];
    if (!use_fp) rr_last = win;
    s_req   = mask;
    s_abort = N'($urandom);           // abort while idle must be ignored
    if (!do_abort && !do_reset) exp_q.push_back({8'(win), d});
    #1;
    check("s_rdy_accept", DW'(s_rdy), DW'(onehot(win)));
    check("busy_idle", DW'(busy), '0);

    // REQ phase, possibly back-pressured
    for (int c = 0; c <= rdy_dly; c++) begin
      @(negedge clk);
      s_req   = N'($urandom);
      s_abort = N'($urandom) & ~onehot(win);
      m_rdy   = (c == rdy_dly);
      #1;
      check("m_req_req", DW'(m_req), DW'(1'b1));
      check("m_addr", DW'(m_addr), DW'(a));
      check("m_type", DW'(m_type), DW'(t));
      check("s_rdy_req", DW'(s_rdy), '0);
      check("busy_req", DW'(busy), DW'(1'b1));
    end

    if (do_reset) begin
      @(negedge clk);               // now in WAIT
      m_rdy = 1'b0; s_req = '0; s_abort = '0; m_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_s_rdy", DW'(s_rdy), '0);
      check("rst_s_valid", DW'(s_valid), '0);
      check("rst_s_data", s_data, '0);
      check("rst_m_req", DW'(m_req), '0);
      check("rst_m_addr", DW'(m_addr), '0);
      check("rst_m_type", DW'(m_type), '0);
      check("rst_busy", DW'(busy), '0);
      @(negedge clk);
      rst_n   = 1'b1;
      rr_last = N - 1;
      m_valid = 1'b1;
      m_data  = d;
      @(negedge clk);
      m_valid = 1'b0;
      #1;
      check("post_rst_busy", DW'(busy), '0);
      check("post_rst_s_data", s_data, '0);
      @(negedge clk);
      return;
    end

    // WAIT phase
    for (int c = 0; c <= val_dly; c++) begin
      @(negedge clk);
      m_rdy   = 1'b0;
      s_abort = N'($urandom) & ~onehot(win);
      if (do_abort && c == 0) s_abort[win] = 1'b1;
      m_valid = (c == val_dly);
      m_data  = m_valid ? d : rand_data();
      #1;
      check("m_req_wait", DW'(m_req), '0);
      check("busy_wait", DW'(busy), DW'(1'b1));
      check("s_valid_wait", DW'(s_valid), '0);
    end

    // RESP: a new request must not be accepted here
    @(negedge clk);
    m_valid = 1'b0;
    m_data  = rand_data();
    s_req   = N'($urandom);
    s_abort = N'($urandom);
    #1;
    check("busy_resp", DW'(busy), DW'(1'b1));
    check("s_rdy_resp", DW'(s_rdy), '0);
    check("m_req_resp", DW'(m_req), '0);
    if (do_abort) check("s_valid_aborted", DW'(s_valid), '0);

    @(negedge clk);
    s_req   = '0;
    s_abort = '0;
    #1;
    check("busy_done", DW'(busy), '0);
    check("s_valid_done", DW'(s_valid), '0);
    check("s_data_hold", s_data, d);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b1; use_fp = 1'b0;
    s_req = '0; s_addr = '0; s_type = '0; s_abort = '0;
    m_rdy = 1'b0; m_valid = 1'b0; m_data = '0;
    #1 rst_n = 1'b0;
    s_req = '1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_s_rdy", DW'(s_rdy), '0);
    check("reset_s_valid", DW'(s_valid), '0);
    check("reset_s_data", s_data, '0);
    check("reset_m_req", DW'(m_req), '0);
    check("reset_m_addr", DW'(m_addr), '0);
    check("reset_m_type", DW'(m_type), '0);
    check("reset_busy", DW'(busy), '0);
    @(negedge clk);
    s_req = '0;
    rst_n = 1'b1;
    @(negedge clk);

    // single request with minimum latency
    do_txn(4'b0100, 0, 0, 1'b0, 1'b0, 1'b1);
    // reset while waiting for data
    do_txn(4'b1111, 0, 2, 1'b0, 1'b1, 1'b0);
    // fairness from reset: 0,1,2,3,0
    repeat (5) do_txn(4'b1111, 0, 0, 1'b0, 1'b0, 1'b0);
    // back-pressure then abort, then a normal request
    do_txn(N'($urandom_range(1, 15)), 5, 1, 1'b1, 1'b0, 1'b0);
    do_txn(4'b1111, 0, 0, 1'b0, 1'b0, 1'b0);
    // random round-robin traffic
    repeat (12) do_txn(N'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                       ($urandom_range(0, 3) == 0), 1'b0, 1'b0);

    // fixed priority
    use_fp = 1'b1;
    repeat (4) do_txn(4'b1111, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) do_txn(4'b1010, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0, 1'b0);
    repeat (8) do_txn(N'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0), 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("exp_q_drained", DW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
